// File: rtl/urv_pipe_ctrl.sv
// Pipeline control glue for the uRV core: per-stage stall/kill generation,
// debug halt/drain sequencing and saturating performance counters.
module urv_pipe_ctrl #(
    parameter int g_num_stages     = 4,
    parameter int g_branch_stage   = 2,
    parameter int g_perf_cnt_width = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [g_num_stages-1:0]     stall_req_i,
    input  logic [g_num_stages-1:0]     stage_valid_i,
    input  logic                        bra_i,
    input  logic                        halt_req_i,
    input  logic                        resume_i,
    input  logic                        perf_clr_i,
    output logic [g_num_stages-1:0]     stall_o,
    output logic [g_num_stages-1:0]     kill_o,
    output logic                        halted_o,
    output logic [g_perf_cnt_width-1:0] perf_stall_cycles_o,
    output logic [g_perf_cnt_width-1:0] perf_bra_count_o
);

    localparam int N = g_num_stages;
    localparam int B = g_branch_stage;
    localparam int W = g_perf_cnt_width;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [B-1:0]   sh;
    logic [B-1:0]   sh_next;
    logic [N-1:0]   stall;
    logic [N-1:0]   kill;
    logic           stall_acc;
    logic           kill_acc;
    logic           bra_accept;
    logic           stall_inc;
    logic           drain_done;
    logic [W-1:0]   stall_cnt;
    logic [W-1:0]   bra_cnt;
    logic           unused_fetch_valid;

    // A stall in any later stage backs up every earlier one; a halted or
    // draining pipeline additionally freezes fetch.
    always_comb begin
        stall     = '0;
        stall_acc = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            stall_acc = stall_acc | stall_req_i[i];
            stall[i]  = stall_acc;
        end
        if (state != ST_RUN) begin
            stall[0] = 1'b1;
        end
    end

    assign bra_accept = bra_i & ~stall[B];
    assign stall_inc  = (state == ST_RUN) & stall[0];

    always_comb begin
        sh_next = sh;
        if (!stall[B]) begin
            sh_next[0] = bra_i;
            for (int k = 1; k < B; k++) begin
                sh_next[k] = sh[k-1];
            end
        end
    end

    // Stage i is killed while any branch younger than i instructions is still
    // in the shadow; stages past the branch stage are never killed.
    always_comb begin
        kill     = '0;
        kill_acc = bra_i;
        for (int i = 1; i <= B; i++) begin
            kill_acc = kill_acc | sh[i-1];
            kill[i]  = kill_acc;
        end
    end

    // Fetch has nothing to drain: it is already frozen while not in RUN.
    assign unused_fetch_valid = stage_valid_i[0];
    assign drain_done         = (stage_valid_i[N-1:1] == '0) && (sh == '0);

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (halt_req_i) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!halt_req_i) begin
                    state_next = ST_RUN;
                end else if (drain_done) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (resume_i) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_RUN;
            sh    <= '0;
        end else begin
            state <= state_next;
            sh    <= sh_next;
        end
    end

    // Counters stick at all-ones; a clear beats any same-cycle increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            bra_cnt   <= '0;
        end else if (perf_clr_i) begin
            stall_cnt <= '0;
            bra_cnt   <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (bra_accept && (bra_cnt != '1)) begin
                bra_cnt <= bra_cnt + CNT_ONE;
            end
        end
    end

    assign stall_o             = stall;
    assign kill_o              = kill;
    assign halted_o            = (state == ST_HALTED);
    assign perf_stall_cycles_o = stall_cnt;
    assign perf_bra_count_o    = bra_cnt;

endmodule
